// File: rtl/riscv_lsu.sv
// RV32I load/store unit: turns one core load/store into a single handshaked
// data-memory request, with byte-lane steering, load extension and a response timeout.
module riscv_lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    size_q;
    logic [1:0]    addr_lo_q;

    logic          misalign_c;
    logic [3:0]    be_c;
    logic [31:0]   wd_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [31:0]   load_c;

    // Request decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        misalign_c = 1'b1;
        be_c       = 4'b1111;
        wd_c       = core_wd_i;
        case (core_size_i)
            3'b000: begin
                misalign_c = 1'b0;
                be_c       = 4'b0001 << core_addr_i[1:0];
                wd_c       = {4{core_wd_i[7:0]}};
            end
            3'b001: begin
                misalign_c = core_addr_i[0];
                be_c       = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_c       = {2{core_wd_i[15:0]}};
            end
            3'b010:  misalign_c = |core_addr_i[1:0];
            3'b100:  misalign_c = core_we_i;
            3'b101:  misalign_c = core_we_i | core_addr_i[0];
            default: misalign_c = 1'b1;
        endcase
        if (!core_we_i) begin
            be_c = 4'b1111;
        end
    end

    // Load extraction from the returned word using the latched size and offset.
    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_c = mem_rd_i[7:0];
            2'd1:    byte_c = mem_rd_i[15:8];
            2'd2:    byte_c = mem_rd_i[23:16];
            default: byte_c = mem_rd_i[31:24];
        endcase
        half_c = addr_lo_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b100:  load_c = {24'd0, byte_c};
            3'b101:  load_c = {16'd0, half_c};
            default: load_c = mem_rd_i;
        endcase
    end

    assign core_misalign_o = (state == S_IDLE) && core_req_i && misalign_c;
    assign core_stall_o    = (state == S_REQ) ||
                             ((state == S_IDLE) && core_req_i && !misalign_c);

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            size_q     <= '0;
            addr_lo_q  <= '0;
            core_rd_o  <= '0;
            core_err_o <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= '0;
            mem_addr_o <= '0;
            mem_wd_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_req_i && !misalign_c) begin
                        state      <= S_REQ;
                        wait_cnt   <= '0;
                        size_q     <= core_size_i;
                        addr_lo_q  <= core_addr_i[1:0];
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= core_we_i;
                        mem_be_o   <= be_c;
                        mem_addr_o <= {core_addr_i[31:2], 2'b00};
                        mem_wd_o   <= wd_c;
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        state     <= S_DONE;
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            core_rd_o <= load_c;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        // Timeout abort: the core sees a zero result plus an error pulse.
                        state      <= S_DONE;
                        mem_req_o  <= 1'b0;
                        core_rd_o  <= '0;
                        core_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    core_err_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: the driver pushes expected memory requests and
// core responses, a memory responder and a core monitor pop and compare them.
module tb_riscv_lsu;

    localparam int MAX_WAIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    riscv_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .core_req_i      (core_req_i),
        .core_we_i       (core_we_i),
        .core_size_i     (core_size_i),
        .core_addr_i     (core_addr_i),
        .core_wd_i       (core_wd_i),
        .core_rd_o       (core_rd_o),
        .core_stall_o    (core_stall_o),
        .core_misalign_o (core_misalign_o),
        .core_err_o      (core_err_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wd_o        (mem_wd_o),
        .mem_rd_i        (mem_rd_i),
        .mem_ready_i     (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        int          delay;
        logic [31:0] rdata;
        int          req_cycles;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stall_cycles;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];
    logic [31:0] model_rd = '0;
    bit bypass = 1'b0;

    // ---------------- reference model ----------------
    function automatic bit model_misaligned(input logic we, input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            3'd2:    return a[1:0] != 2'd0;
            3'd4:    return we;
            3'd5:    return we || a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] sz, input logic [1:0] lo);
        if (!we) return 4'hF;
        case (sz)
            3'd0:    return 4'(1 << lo);
            3'd1:    return lo[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] sz, input logic [31:0] d);
        case (sz)
            3'd0:    return (d & 32'hFF) * 32'h0101_0101;
            3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * lo[1])) & 32'hFFFF;
        case (sz)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // ---------------- memory responder ----------------
    mem_exp_t    cur;
    int          rcnt = 0;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_wd;

    initial begin
        mem_ready_i = 1'b0;
        mem_rd_i    = '0;
        forever begin
            @(negedge clk_i);
            if (bypass) begin
                rcnt        = 0;
                mem_ready_i = 1'b0;
            end else if (mem_req_o) begin
                if (rcnt == 0) begin
                    if (mem_q.size() == 0) begin
                        check("mem_req_unexpected", mem_req_o, 1'b0);
                        cur = '{we: 1'b0, be: 4'h0, addr: 32'h0, wd: 32'h0, delay: 0, rdata: 32'h0, req_cycles: 1};
                    end else begin
                        cur = mem_q.pop_front();
                        check("mem_we", mem_we_o, cur.we);
                        check("mem_be", mem_be_o, cur.be);
                        check("mem_addr", mem_addr_o, cur.addr);
                        if (cur.we) check("mem_wd", mem_wd_o, cur.wd);
                    end
                    cap_we   = mem_we_o;
                    cap_be   = mem_be_o;
                    cap_addr = mem_addr_o;
                    cap_wd   = mem_wd_o;
                end else begin
                    check("mem_stable_addr", mem_addr_o, cap_addr);
                    check("mem_stable_ctl", {mem_we_o, mem_be_o}, {cap_we, cap_be});
                    check("mem_stable_wd", mem_wd_o, cap_wd);
                end
                mem_ready_i = (rcnt == cur.delay);
                mem_rd_i    = mem_ready_i ? cur.rdata : $urandom;
                rcnt++;
            end else begin
                if (rcnt != 0) check("req_cycles", rcnt, cur.req_cycles);
                rcnt        = 0;
                // Ready outside a request must be ignored by the DUT.
                mem_ready_i = 1'($urandom_range(0, 1));
                mem_rd_i    = $urandom;
            end
        end
    end

    // ---------------- core-side monitor ----------------
    initial begin
        int   scnt;
        logic prev_stall;
        scnt = 0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk_i);
            if (bypass || rst_i) begin
                scnt = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !core_stall_o) begin
                    if (resp_q.size() == 0) begin
                        check("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        resp_exp_t e;
                        e = resp_q.pop_front();
                        check("core_rd", core_rd_o, e.rd);
                        check("core_err", core_err_o, e.err);
                        check("stall_cycles", scnt, e.stall_cycles);
                    end
                    scnt = 0;
                end else begin
                    check("err_outside_done", core_err_o, 1'b0);
                end
                if (core_stall_o) scnt++;
                prev_stall = core_stall_o;
            end
        end
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge with the DUT idle; returns the same way.
    task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input int delay, input logic [31:0] rdata);
        bit mis;
        int guard;
        mis = model_misaligned(we, sz, a);
        if (!mis) begin
            mem_exp_t  m;
            resp_exp_t r;
            bit        tmo;
            tmo = (delay >= MAX_WAIT);
            m.we = we;
            m.be = model_be(we, sz, a[1:0]);
            m.addr = a & 32'hFFFF_FFFC;
            m.wd = model_wd(sz, d);
            m.delay = delay;
            m.rdata = rdata;
            m.req_cycles = tmo ? MAX_WAIT : delay + 1;
            if (tmo) model_rd = '0;
            else if (!we) model_rd = model_load(sz, a[1:0], rdata);
            r.rd = model_rd;
            r.err = tmo;
            r.stall_cycles = m.req_cycles + 1;
            mem_q.push_back(m);
            resp_q.push_back(r);
        end
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = a;
        core_wd_i   = d;
        @(negedge clk_i);
        check("misalign", core_misalign_o, mis);
        if (mis) begin
            check("misalign_stall", core_stall_o, 1'b0);
            @(posedge clk_i);
            #1 core_req_i = 1'b0;
            @(negedge clk_i);
            check("misalign_no_req", mem_req_o, 1'b0);
            @(posedge clk_i);
            #1;
        end else begin
            guard = 0;
            do begin
                @(negedge clk_i);
                guard++;
            end while (core_stall_o && guard < 50);
            if (guard >= 50) check("stall_timeout", core_stall_o, 1'b0);
            // Request is still held during DONE, which must ignore it.
            @(posedge clk_i);
            #1 core_req_i = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = '0;
        core_addr_i = '0;
        core_wd_i   = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_rd", core_rd_o, 32'h0);
        check("rst_ctl", {core_stall_o, core_misalign_o, core_err_o, mem_req_o, mem_we_o, mem_be_o}, 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wd", mem_wd_o, 32'h0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Directed cases
        issue(1'b0, 3'd2, 32'h10, 32'h0, 0, 32'hDEAD_BEEF);   // LW zero-wait
        issue(1'b0, 3'd0, 32'h13, 32'h0, 0, 32'h8012_3456);   // LB -> FFFFFF80
        issue(1'b0, 3'd4, 32'h13, 32'h0, 1, 32'h8012_3456);   // LBU -> 00000080
        issue(1'b1, 3'd1, 32'h22, 32'h0000_ABCD, 0, 32'h0);   // SH upper half
        issue(1'b1, 3'd0, 32'h31, 32'h1234_5678, 2, 32'h0);   // SB lane 1
        issue(1'b0, 3'd2, 32'h06, 32'h0, 0, 32'h0);           // LW misaligned
        issue(1'b0, 3'd1, 32'h07, 32'h0, 0, 32'h0);           // LH misaligned
        issue(1'b0, 3'd3, 32'h08, 32'h0, 0, 32'h0);           // illegal size
        issue(1'b1, 3'd4, 32'h08, 32'h0, 0, 32'h0);           // BU store illegal
        issue(1'b0, 3'd5, 32'h42, 32'h0, 3, 32'hF00D_9ABC);   // HU, ready on last allowed cycle
        issue(1'b0, 3'd1, 32'h42, 32'h0, 3, 32'hF00D_9ABC);   // LH sign-extend
        issue(1'b0, 3'd2, 32'h50, 32'h0, 1000, 32'h0);        // timeout
        issue(1'b1, 3'd2, 32'h54, 32'hCAFE_F00D, 1000, 32'h0);// store timeout

        // Randomised traffic, including occasional timeouts and idle gaps
        for (int i = 0; i < 200; i++) begin
            int gap;
            int dly;
            dly = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, dly, $urandom);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk_i);
                #1;
            end
        end

        // Reset in the middle of a request
        repeat (3) @(posedge clk_i);
        #1 bypass = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h40;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("rst_mid_req_active", {mem_req_o, core_stall_o}, 2'b11);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        core_req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_req_cleared", {mem_req_o, core_stall_o, core_err_o}, 3'b000);
        check("rst_mid_rd", core_rd_o, 32'h0);
        model_rd = '0;
        @(posedge clk_i);
        #1 bypass = 1'b0;
        issue(1'b0, 3'd2, 32'h44, 32'h0, 3, 32'h1357_9BDF);  // full wait budget after reset
        issue(1'b0, 3'd0, 32'h45, 32'h0, 0, 32'h1357_9BDF);

        repeat (4) @(posedge clk_i);
        check("mem_q_drained", mem_q.size(), 32'd0);
        check("resp_q_drained", resp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
